// File: rtl/ddy_obegi.sv
// Machine-mode CSR file: combinational read port, single write port,
// 64-bit mcycle/minstret counters and a one-cycle illegal-write flag.
module ddy_obegi #(
  parameter logic [31:0] MISA_DEGER = 32'h4000_0100,
  parameter logic [31:0] HARTID     = 32'h0
) (
  input  logic        clk_g,
  input  logic        rst_g,
  input  logic        ddy_yaz_g,
  input  logic [11:0] ddy_yaz_hedef_g,
  input  logic [31:0] ddy_yaz_veri_g,
  input  logic [11:0] ddy_oku_adres_g,
  output logic [31:0] ddy_oku_veri_c,
  output logic        ddy_oku_gecerli_c,
  input  logic        emekli_g,
  output logic        ddy_hata_r,
  output logic [31:0] mtvec_c,
  output logic [31:0] mepc_c,
  output logic        mstatus_mie_c
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic              mie_bit_q, mie_bit_d;
  logic              mpie_q, mpie_d;
  logic [2:0]        mie_q, mie_d;         // mie bits {11,7,3}
  logic [XLEN-1:2]   mtvec_q, mtvec_d;
  logic [XLEN-1:2]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;
  logic [CW-1:0]     mcycle_q, mcycle_d;
  logic [CW-1:0]     minstret_q, minstret_d;
  logic              hata_q, hata_d;
  logic              wr_ok;
  logic [XLEN-1:0]   mstatus_rd;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};

  // Writable-address decode; anything else under a strobe is illegal
  always_comb begin
    wr_ok = 1'b0;
    if (ddy_yaz_g) begin
      case (ddy_yaz_hedef_g)
        A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
        A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: wr_ok = 1'b1;
        default: wr_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + CW'(1);
    minstret_d = emekli_g ? (minstret_q + CW'(1)) : minstret_q;
    hata_d     = ddy_yaz_g & ~wr_ok;
    // A counter write replaces one half and suppresses that counter's increment
    if (wr_ok) begin
      case (ddy_yaz_hedef_g)
        A_MSTATUS: begin
          mie_bit_d = ddy_yaz_veri_g[3];
          mpie_d    = ddy_yaz_veri_g[7];
        end
        A_MIE:       mie_d      = {ddy_yaz_veri_g[11], ddy_yaz_veri_g[7], ddy_yaz_veri_g[3]};
        A_MTVEC:     mtvec_d    = ddy_yaz_veri_g[XLEN-1:2];
        A_MSCRATCH:  mscratch_d = ddy_yaz_veri_g;
        A_MEPC:      mepc_d     = ddy_yaz_veri_g[XLEN-1:2];
        A_MCAUSE:    mcause_d   = ddy_yaz_veri_g;
        A_MTVAL:     mtval_d    = ddy_yaz_veri_g;
        A_MCYCLE:    mcycle_d   = {mcycle_q[CW-1:XLEN], ddy_yaz_veri_g};
        A_MCYCLEH:   mcycle_d   = {ddy_yaz_veri_g, mcycle_q[XLEN-1:0]};
        A_MINSTRET:  minstret_d = {minstret_q[CW-1:XLEN], ddy_yaz_veri_g};
        A_MINSTRETH: minstret_d = {ddy_yaz_veri_g, minstret_q[XLEN-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 3'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      hata_q     <= 1'b0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      hata_q     <= hata_d;
    end
  end

  // Read mux returns current (pre-write) contents
  always_comb begin
    ddy_oku_veri_c    = '0;
    ddy_oku_gecerli_c = 1'b1;
    case (ddy_oku_adres_g)
      A_MSTATUS:              ddy_oku_veri_c = mstatus_rd;
      A_MISA:                 ddy_oku_veri_c = MISA_DEGER;
      A_MIE:                  ddy_oku_veri_c = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      A_MTVEC:                ddy_oku_veri_c = {mtvec_q, 2'b00};
      A_MSCRATCH:             ddy_oku_veri_c = mscratch_q;
      A_MEPC:                 ddy_oku_veri_c = {mepc_q, 2'b00};
      A_MCAUSE:               ddy_oku_veri_c = mcause_q;
      A_MTVAL:                ddy_oku_veri_c = mtval_q;
      A_MIP:                  ddy_oku_veri_c = '0;
      A_MCYCLE, A_CYCLE:      ddy_oku_veri_c = mcycle_q[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH:    ddy_oku_veri_c = mcycle_q[CW-1:XLEN];
      A_MINSTRET, A_INSTRET:  ddy_oku_veri_c = minstret_q[XLEN-1:0];
      A_MINSTRETH, A_INSTRETH: ddy_oku_veri_c = minstret_q[CW-1:XLEN];
      A_MHARTID:              ddy_oku_veri_c = HARTID;
      default:                ddy_oku_gecerli_c = 1'b0;
    endcase
  end

  assign ddy_hata_r    = hata_q;
  assign mtvec_c       = {mtvec_q, 2'b00};
  assign mepc_c        = {mepc_q, 2'b00};
  assign mstatus_mie_c = mie_bit_q;

endmodule

// File: tb/tb_ddy_obegi.sv
// Scoreboard bench for ddy_obegi: expectations are queued when stimulus is
// driven and popped when the CSR file presents the result.
module tb_ddy_obegi;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        ddy_yaz_g;
  logic [11:0] ddy_yaz_hedef_g;
  logic [31:0] ddy_yaz_veri_g;
  logic [11:0] ddy_oku_adres_g;
  logic [31:0] ddy_oku_veri_c;
  logic        ddy_oku_gecerli_c;
  logic        emekli_g;
  logic        ddy_hata_r;
  logic [31:0] mtvec_c;
  logic [31:0] mepc_c;
  logic        mstatus_mie_c;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  ddy_obegi dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .ddy_yaz_g(ddy_yaz_g), .ddy_yaz_hedef_g(ddy_yaz_hedef_g), .ddy_yaz_veri_g(ddy_yaz_veri_g),
    .ddy_oku_adres_g(ddy_oku_adres_g), .ddy_oku_veri_c(ddy_oku_veri_c),
    .ddy_oku_gecerli_c(ddy_oku_gecerli_c), .emekli_g(emekli_g), .ddy_hata_r(ddy_hata_r),
    .mtvec_c(mtvec_c), .mepc_c(mepc_c), .mstatus_mie_c(mstatus_mie_c)
  );

  always #5 clk_g = ~clk_g;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_g);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    ddy_yaz_g = 1'b1;
    ddy_yaz_hedef_g = a;
    ddy_yaz_veri_g = d;
  endtask

  task automatic idle();
    ddy_yaz_g = 1'b0;
    ddy_yaz_hedef_g = 12'hFFF;
    ddy_yaz_veri_g = 32'hA5A5_A5A5;
  endtask

  task automatic rd(input logic [11:0] a);
    ddy_oku_adres_g = a;
    #1;
  endtask

  task automatic test_reset();
    rst_g = 1'b1; emekli_g = 1'b0; idle(); ddy_oku_adres_g = 12'h300;
    tick(); tick();
    exp_q.push_back(32'h0000_1800);
    rd(12'h300); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL reset_mstatus got=%h exp=%h", ddy_oku_veri_c, e); end
    exp_q.push_back(32'h0);
    rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL reset_mcycle got=%h exp=%h", ddy_oku_veri_c, e); end
    checks++;
    if (ddy_hata_r !== 1'b0 || mtvec_c !== 32'h0) begin failures++; $display("FAIL reset_outs got=%b/%h exp=0/0", ddy_hata_r, mtvec_c); end
    rst_g = 1'b0;
    exp_q.push_back(32'h1);
    tick(); rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL reset_release_mcycle got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  task automatic test_mtvec();
    wr(12'h305, 32'h8000_0103);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h8000_0100);
    rd(12'h305); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mtvec_same_cycle got=%h exp=%h", ddy_oku_veri_c, e); end
    tick(); idle(); rd(12'h305); e = exp_q.pop_front(); checks++;
    if (mtvec_c !== e || ddy_oku_veri_c !== e) begin failures++; $display("FAIL mtvec_new got=%h/%h exp=%h", mtvec_c, ddy_oku_veri_c, e); end
    wr(12'h341, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFC);
    tick(); idle(); rd(12'h341); e = exp_q.pop_front(); checks++;
    if (mepc_c !== e || ddy_oku_veri_c !== e) begin failures++; $display("FAIL mepc_align got=%h/%h exp=%h", mepc_c, ddy_oku_veri_c, e); end
  endtask

  task automatic test_mstatus_mie();
    wr(12'h300, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_1888);
    tick(); idle(); rd(12'h300); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e || mstatus_mie_c !== 1'b1) begin failures++; $display("FAIL mstatus_ones got=%h mie=%b exp=%h mie=1", ddy_oku_veri_c, mstatus_mie_c, e); end
    wr(12'h300, 32'h0000_0080);
    exp_q.push_back(32'h0000_1880);
    tick(); idle(); rd(12'h300); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e || mstatus_mie_c !== 1'b0) begin failures++; $display("FAIL mstatus_mpie got=%h mie=%b exp=%h mie=0", ddy_oku_veri_c, mstatus_mie_c, e); end
    wr(12'h304, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0888);
    tick(); idle(); rd(12'h304); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mie_mask got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  task automatic test_full_regs();
    logic [11:0] addrs[3];
    logic [31:0] v;
    addrs = '{12'h340, 12'h342, 12'h343};
    for (int i = 0; i < 3; i++) begin
      v = 32'($urandom);
      wr(addrs[i], v);
      exp_q.push_back(v);
      tick(); idle(); rd(addrs[i]); e = exp_q.pop_front(); checks++;
      if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL full_reg_%h got=%h exp=%h", addrs[i], ddy_oku_veri_c, e); end
    end
    exp_q.push_back(32'h4000_0100);
    rd(12'h301); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e || ddy_oku_gecerli_c !== 1'b1) begin failures++; $display("FAIL misa got=%h v=%b exp=%h v=1", ddy_oku_veri_c, ddy_oku_gecerli_c, e); end
    exp_q.push_back(32'h0);
    rd(12'h344); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e || ddy_oku_gecerli_c !== 1'b1) begin failures++; $display("FAIL mip got=%h v=%b exp=%h v=1", ddy_oku_veri_c, ddy_oku_gecerli_c, e); end
  endtask

  task automatic test_mcycle_carry();
    wr(12'hB80, 32'h0);
    tick();
    wr(12'hB00, 32'hFFFF_FFFF);
    tick(); idle();
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h1);
    rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mcycle_lo_set got=%h exp=%h", ddy_oku_veri_c, e); end
    rd(12'hB80); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mcycle_hi_set got=%h exp=%h", ddy_oku_veri_c, e); end
    tick();
    rd(12'hC00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mcycle_lo_wrap got=%h exp=%h", ddy_oku_veri_c, e); end
    rd(12'hC80); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL mcycle_carry got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    rd(12'hB00); v = ddy_oku_veri_c;
    wr(12'hC00, 32'hDEAD_BEEF);
    exp_q.push_back(v + 32'd1);
    tick(); idle(); rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e || ddy_hata_r !== 1'b1) begin failures++; $display("FAIL illegal_c00 got=%h hata=%b exp=%h hata=1", ddy_oku_veri_c, ddy_hata_r, e); end
    tick(); checks++;
    if (ddy_hata_r !== 1'b0) begin failures++; $display("FAIL illegal_pulse_end got=%b exp=0", ddy_hata_r); end
    wr(12'h123, 32'h1234_5678);
    rd(12'h123); checks++;
    if (ddy_oku_gecerli_c !== 1'b0 || ddy_oku_veri_c !== 32'h0) begin failures++; $display("FAIL unimpl_read got=%h v=%b exp=0 v=0", ddy_oku_veri_c, ddy_oku_gecerli_c); end
    tick(); idle(); checks++;
    if (ddy_hata_r !== 1'b1) begin failures++; $display("FAIL illegal_123 got=%b exp=1", ddy_hata_r); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs[3];
    addrs = '{12'hF14, 12'h301, 12'h344};
    for (int i = 0; i < 3; i++) begin
      wr(addrs[i], 32'hFFFF_FFFF);
      tick(); checks++;
      if (ddy_hata_r !== 1'b1) begin failures++; $display("FAIL b2b_hata_%0d got=%b exp=1", i, ddy_hata_r); end
    end
    idle(); tick(); checks++;
    if (ddy_hata_r !== 1'b0) begin failures++; $display("FAIL b2b_hata_end got=%b exp=0", ddy_hata_r); end
    exp_q.push_back(32'h0);
    rd(12'hF14); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL b2b_hartid got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  task automatic test_minstret();
    wr(12'hB02, 32'h0); tick();
    wr(12'hB82, 32'h0); tick();
    for (int i = 1; i <= 5; i++) begin
      emekli_g = 1'b1;
      if (i == 3) wr(12'hB82, 32'h7); else idle();
      tick();
    end
    emekli_g = 1'b0; idle();
    exp_q.push_back(32'h4); exp_q.push_back(32'h7);
    rd(12'hC02); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL minstret_lo got=%h exp=%h", ddy_oku_veri_c, e); end
    rd(12'hB82); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL minstret_hi got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  task automatic test_reset_during_write();
    for (int i = 0; i < 4; i++) begin
      wr(12'h340, 32'(i + 100));
      if (i == 3) rst_g = 1'b1;
      tick();
    end
    idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    rd(12'h340); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL rst_mscratch got=%h exp=%h", ddy_oku_veri_c, e); end
    rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL rst_mcycle got=%h exp=%h", ddy_oku_veri_c, e); end
    rd(12'hC02); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL rst_minstret got=%h exp=%h", ddy_oku_veri_c, e); end
    rst_g = 1'b0;
    tick(); rd(12'hB00); e = exp_q.pop_front(); checks++;
    if (ddy_oku_veri_c !== e) begin failures++; $display("FAIL rst_resume got=%h exp=%h", ddy_oku_veri_c, e); end
  endtask

  initial begin
    test_reset();
    test_mtvec();
    test_mstatus_mie();
    test_full_regs();
    test_mcycle_carry();
    test_illegal();
    test_back_to_back();
    test_minstret();
    test_reset_during_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddy_obegi.md
DDY_OBEGI -- requirements
Module: ddy_obegi

Interface
REQ-001 Parameter MISA_DEGER, default 32'h4000_0100, read-only value returned for misa (0x301).
REQ-002 Parameter HARTID, default 32'h0, read-only value returned for mhartid (0xF14).
REQ-003 The clock is clk_g (input, 1); all state SHALL update on its rising edge.
REQ-004 The reset is rst_g (input, 1): synchronous, active-high.
REQ-005 ddy_yaz_g  input  1  CSR write strobe, driven by the register-write stage.
REQ-006 ddy_yaz_hedef_g  input  12  CSR address to write.
REQ-007 ddy_yaz_veri_g  input  32  CSR write data.
REQ-008 ddy_oku_adres_g  input  12  CSR read address.
REQ-009 ddy_oku_veri_c  output  32  combinational read data.
REQ-010 ddy_oku_gecerli_c  output  1  combinational; 1 when the read address is implemented.
REQ-011 emekli_g  input  1  one instruction retired this cycle.
REQ-012 ddy_hata_r  output  1  registered one-cycle pulse flagging an illegal write.
REQ-013 mtvec_c, mepc_c  output  32 each  current register contents.
REQ-014 mstatus_mie_c  output  1  current mstatus.MIE.

Function
REQ-015 Implemented read/write CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
REQ-016 Implemented read-only CSRs: misa 0x301, mhartid 0xF14, mip 0x344 (reads 0), cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 (shadows of mcycle/minstret halves).
REQ-017 The read path SHALL be purely combinational.
REQ-018 A read SHALL return the pre-write value; a write becomes visible on the cycle after ddy_yaz_g.
REQ-019 A read of an unimplemented address SHALL return 0 with ddy_oku_gecerli_c=0.
REQ-020 mstatus write mask: only bits 3 (MIE) and 7 (MPIE) are writable; bits 12:11 (MPP) read as 2'b11; all other bits read 0.
REQ-021 mtvec and mepc SHALL force bits 1:0 to 0 on write (direct mode, 4-byte alignment).
REQ-022 mie write mask: only bits 3, 7 and 11 are writable; all other bits read 0.
REQ-023 mscratch, mcause and mtval SHALL store all 32 bits.
REQ-024 mcycle is a 64-bit counter that SHALL increment by 1 every cycle when not in reset.
REQ-025 minstret is a 64-bit counter that SHALL increment by 1 in each cycle where emekli_g=1.
REQ-026 Both counters SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-027 Counter write to a low half, same cycle: the new value is {old_hi, wdata}, with no increment that cycle.
REQ-028 Counter write to a high half, same cycle: the new value is {wdata, old_lo}, with no increment that cycle.
REQ-029 A write to a counter SHALL suppress only that counter's increment; the other counter is unaffected.
REQ-030 A carry from the low half into the high half SHALL occur in the same cycle as the low-half wrap.
REQ-031 Illegal write = ddy_yaz_g=1 to a read-only or unimplemented address.
REQ-032 An illegal write SHALL change no state and SHALL set ddy_hata_r=1 for exactly the next cycle.
REQ-033 Back-to-back illegal writes SHALL keep ddy_hata_r high for the same number of cycles.
REQ-034 When ddy_yaz_g=0, ddy_yaz_hedef_g and ddy_yaz_veri_g are don't-care and SHALL have no effect.

Reset
REQ-035 With rst_g=1 at a clock edge, every CSR and both counters SHALL become 0 and ddy_hata_r SHALL become 0.
REQ-036 Reset SHALL override any same-cycle write or increment.
REQ-037 After reset, mstatus SHALL read 32'h0000_1800 (MPP fixed).
REQ-038 Counting SHALL resume on the first cycle with rst_g=0; mcycle reads 1 one cycle after reset is released.

Verification
REQ-039 Write mtvec=32'h8000_0103 -> next cycle mtvec_c=32'h8000_0100; same-cycle read returns the old value.
REQ-040 Write mstatus=32'hFFFF_FFFF -> read 32'h0000_1888 and mstatus_mie_c=1.
REQ-041 Write mcycle=32'hFFFF_FFFF with mcycleh=0 -> next read 0xFFFF_FFFF; one cycle later low=0, mcycleh=1.
REQ-042 Write 0xC00 or 0x123 -> ddy_hata_r=1 for one cycle; cycle/mcycle unaffected by the write; ddy_oku_gecerli_c=0 for 0x123.
REQ-043 emekli_g=1 for 5 cycles while minstreth is written 32'h7 at cycle 3 -> final minstret={7, 4}.
REQ-044 Assert rst_g during a continuous mscratch write stream -> mscratch=0 and counters=0 on the following cycle.
